// File: rtl/nes_bus_pkg.sv
// Shared CPU-bus constants and the sprite-DMA state encoding.
// The optional DMA_ALIGN_EN build uses ST_ALIGN; the default build never enters it.
package nes_bus_pkg;

  localparam logic [15:0] PPU_OAMADDR_ADDR = 16'h2003;
  localparam logic [15:0] OAM_DATA_ADDR    = 16'h2004;
  localparam logic [15:0] DMA_REG_ADDR     = 16'h4014;
  localparam logic [15:0] APU_STATUS_ADDR  = 16'h4015;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_RD    = 3'd3,
    ST_WR    = 3'd4
  } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: snoops CPU writes to $4014, halts the CPU and copies one 256-byte page to $2004.
// Build option: define DMA_ALIGN_EN to add the odd-cycle ALIGN dummy state.
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter logic [15:0] DMA_REG_ADDR_P  = DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR_P = OAM_DATA_ADDR
) (
  input  logic        i_cpu_clk,
  input  logic        i_cpu_rstn,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_wn,
  input  logic [7:0]  i_cpu_wdata,
  input  logic [7:0]  i_bus_rdata,
  output logic        o_cpu_rdy,
  output logic        o_dma_active,
  output logic [15:0] o_dma_addr,
  output logic        o_dma_wn,
  output logic [7:0]  o_dma_wdata,
  output logic        o_dma_busy
);

  dma_state_e state, state_nx;
  logic [7:0] page;
  logic [7:0] cnt;
  logic       trigger;

  // Handshake: o_cpu_rdy is the CPU's ready; while it is low the CPU holds its bus
  // cycle and o_dma_active hands the shared bus to this block for the whole transfer.
  assign trigger = (state == ST_IDLE) && (i_cpu_addr == DMA_REG_ADDR_P) && !i_cpu_wn;

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) begin
      state <= ST_IDLE;
      page  <= 8'h00;
      cnt   <= 8'h00;
    end else begin
      state <= state_nx;
      if (trigger) begin
        page <= i_cpu_wdata;
        cnt  <= 8'h00;
      end else if (state == ST_WR) begin
        cnt  <= cnt + 8'h01;
      end
    end
  end

`ifdef DMA_ALIGN_EN
  // Free-running get/put parity; 0 (even) on the first cycle after reset.
  logic parity;

  always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
    if (!i_cpu_rstn) parity <= 1'b0;
    else             parity <= ~parity;
  end
`endif

  always_comb begin
    state_nx     = state;
    o_cpu_rdy    = 1'b1;
    o_dma_active = 1'b0;
    o_dma_busy   = 1'b0;
    o_dma_addr   = 16'h0000;
    o_dma_wn     = 1'b1;
    o_dma_wdata  = 8'h00;
    case (state)
      ST_IDLE: begin
        if (trigger) state_nx = ST_HALT;
      end
      ST_HALT: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_dma_busy   = 1'b1;
        o_dma_addr   = {page, cnt};
`ifdef DMA_ALIGN_EN
        state_nx     = parity ? ST_ALIGN : ST_RD;
`else
        state_nx     = ST_RD;
`endif
      end
      ST_ALIGN: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_dma_busy   = 1'b1;
        o_dma_addr   = {page, cnt};
        state_nx     = ST_RD;
      end
      ST_RD: begin
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_dma_busy   = 1'b1;
        o_dma_addr   = {page, cnt};
        state_nx     = ST_WR;
      end
      ST_WR: begin
        // Read data from the previous RD cycle flows straight onto the write bus.
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
        o_dma_busy   = 1'b1;
        o_dma_addr   = OAM_DATA_ADDR_P;
        o_dma_wn     = 1'b0;
        o_dma_wdata  = i_bus_rdata;
        state_nx     = (cnt == 8'hFF) ? ST_IDLE : ST_RD;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: CPU-side snoop driver, RAM/bus model and PPU OAM model.
// Expected lengths assume the default build unless DMA_ALIGN_EN is defined for the bench too.
module tb_oam_dma_ctrl;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_wn;
  logic [7:0]  cpu_wdata;
  logic [7:0]  bus_rdata;
  logic        cpu_rdy;
  logic        dma_active;
  logic [15:0] dma_addr;
  logic        dma_wn;
  logic [7:0]  dma_wdata;
  logic        dma_busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  oam [0:255];
  logic [7:0]  oam_addr;
  int          wr_cnt;
  int          low_cnt;
  int          cyc_since_rst;
  logic [15:0] bus_addr;

  oam_dma_ctrl dut (
    .i_cpu_clk   (clk),
    .i_cpu_rstn  (rst_n),
    .i_cpu_addr  (cpu_addr),
    .i_cpu_wn    (cpu_wn),
    .i_cpu_wdata (cpu_wdata),
    .i_bus_rdata (bus_rdata),
    .o_cpu_rdy   (cpu_rdy),
    .o_dma_active(dma_active),
    .o_dma_addr  (dma_addr),
    .o_dma_wn    (dma_wn),
    .o_dma_wdata (dma_wdata),
    .o_dma_busy  (dma_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // shared bus: read data is valid the cycle after the address
  assign bus_addr = dma_active ? dma_addr : cpu_addr;
  always @(posedge clk) bus_rdata <= mem[bus_addr];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc_since_rst <= 0;
    else        cyc_since_rst <= cyc_since_rst + 1;
  end

  // PPU OAMDATA model with OAMADDR auto-increment, plus halt-length counter
  always @(negedge clk) begin
    if (!cpu_rdy) low_cnt = low_cnt + 1;
    if (dma_active && !dma_wn && dma_addr == 16'h2004) begin
      oam[oam_addr] = dma_wdata;
      oam_addr      = oam_addr + 8'h01;
      wr_cnt        = wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cpu_access(input logic [15:0] a, input logic wn, input logic [7:0] d);
    @(negedge clk);
    cpu_addr  = a;
    cpu_wn    = wn;
    cpu_wdata = d;
    @(posedge clk);
    #1;
    cpu_addr  = 16'h0000;
    cpu_wn    = 1'b1;
    cpu_wdata = 8'h00;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (dma_busy && n < 800) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_in_bound"}, {31'd0, dma_busy}, 32'd0);
  endtask

  task automatic prep(input logic [7:0] start_oam);
    @(negedge clk);
    wr_cnt   = 0;
    low_cnt  = 0;
    oam_addr = start_oam;
  endtask

  int bad;
  int exp_len;

  initial begin
    cpu_addr = 16'h0000; cpu_wn = 1'b1; cpu_wdata = 8'h00;
    wr_cnt = 0; low_cnt = 0; oam_addr = 8'h00;
    for (int i = 0; i < 65536; i++) mem[i] = 8'hEE;
    for (int i = 0; i < 256; i++) begin
      oam[i]          = 8'h00;
      mem[16'h0200+i] = i[7:0];
      mem[16'h0700+i] = i[7:0] ^ 8'hA5;
      mem[16'h0300+i] = 8'h30 + i[7:0];
      mem[16'h0500+i] = ~i[7:0];
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdy",    {31'd0, cpu_rdy},    32'd1);
    check("rst_active", {31'd0, dma_active}, 32'd0);
    check("rst_addr",   {16'd0, dma_addr},   32'd0);
    check("rst_wn",     {31'd0, dma_wn},     32'd1);
    check("rst_wdata",  {24'd0, dma_wdata},  32'd0);
    check("rst_busy",   {31'd0, dma_busy},   32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // page $02, RAM[$0200+i]=i
    prep(8'h00);
    cpu_access(16'h4014, 1'b0, 8'h02);
    check("halt_rdy",  {31'd0, cpu_rdy},    32'd0);
    check("halt_act",  {31'd0, dma_active}, 32'd1);
    check("halt_addr", {16'd0, dma_addr},   32'h0200);
    check("halt_wn",   {31'd0, dma_wn},     32'd1);
`ifndef DMA_ALIGN_EN
    @(posedge clk); #1;
    check("rd0_addr", {16'd0, dma_addr}, 32'h0200);
    check("rd0_wn",   {31'd0, dma_wn},   32'd1);
    @(posedge clk); #1;
    check("wr0_addr",  {16'd0, dma_addr},  32'h2004);
    check("wr0_wn",    {31'd0, dma_wn},    32'd0);
    check("wr0_wdata", {24'd0, dma_wdata}, 32'h00);
    @(posedge clk); #1;
    check("rd1_addr", {16'd0, dma_addr}, 32'h0201);
`endif
    wait_idle("p02");
    check("p02_writes", wr_cnt, 32'd256);
`ifdef DMA_ALIGN_EN
    check("p02_len_range", {31'd0, (low_cnt == 513 || low_cnt == 514)}, 32'd1);
`else
    check("p02_len", low_cnt, 32'd513);
`endif
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== i[7:0]) bad++;
    check("p02_oam_data", bad, 32'd0);
    check("p02_oam_ff", {24'd0, oam[255]}, 32'hFF);
    @(negedge clk);
    check("p02_idle_rdy",  {31'd0, cpu_rdy},    32'd1);
    check("p02_idle_act",  {31'd0, dma_active}, 32'd0);
    check("p02_idle_addr", {16'd0, dma_addr},   32'd0);

`ifdef DMA_ALIGN_EN
    // land HALT on odd parity: trigger edge at even cycle index -> HALT on odd cycle
    for (int k = 0; k < 2; k++) begin
      prep(8'h00);
      @(negedge clk);
      if ((cyc_since_rst % 2) != k) @(negedge clk);
      exp_len = 513 + ((cyc_since_rst + 1) % 2);
      cpu_addr = 16'h4014; cpu_wn = 1'b0; cpu_wdata = 8'h02;
      @(posedge clk); #1;
      cpu_addr = 16'h0000; cpu_wn = 1'b1; cpu_wdata = 8'h00;
      wait_idle("align");
      check("align_len", low_cnt, exp_len);
      check("align_writes", wr_cnt, 32'd256);
    end
`endif

    // page $07 with OAMADDR=$10: destination wraps past $FF
    prep(8'h10);
    cpu_access(16'h4014, 1'b0, 8'h07);
    wait_idle("p07");
    check("p07_writes", wr_cnt, 32'd256);
    check("p07_oam10", {24'd0, oam[8'h10]}, {24'd0, 8'h00 ^ 8'hA5});
    check("p07_oamff", {24'd0, oam[8'hFF]}, {24'd0, 8'hEF ^ 8'hA5});
    check("p07_oam00", {24'd0, oam[8'h00]}, {24'd0, 8'hF0 ^ 8'hA5});
    check("p07_oam0f", {24'd0, oam[8'h0F]}, {24'd0, 8'hFF ^ 8'hA5});
    check("p07_oamaddr_wrap", {24'd0, oam_addr}, 32'h10);

    // retrigger while busy must be ignored
    prep(8'h00);
    cpu_access(16'h4014, 1'b0, 8'h05);
    repeat (20) @(negedge clk);
    cpu_addr = 16'h4014; cpu_wn = 1'b0; cpu_wdata = 8'h02;
    repeat (3) @(negedge clk);
    cpu_addr = 16'h0000; cpu_wn = 1'b1; cpu_wdata = 8'h00;
    wait_idle("retrig");
    check("retrig_writes", wr_cnt, 32'd256);
    bad = 0;
    for (int i = 0; i < 256; i++) if (oam[i] !== ~i[7:0]) bad++;
    check("retrig_page_kept", bad, 32'd0);
    repeat (5) @(negedge clk);
    check("retrig_no_rerun", {31'd0, dma_busy}, 32'd0);

    // reset when the counter reaches $40
    prep(8'h00);
    cpu_access(16'h4014, 1'b0, 8'h03);
    bad = 1;
    for (int n = 0; n < 600 && bad != 0; n++) begin
      @(negedge clk);
      if (dma_busy && dma_wn && dma_addr == 16'h0340) bad = 0;
    end
    check("rst_mid_reached", bad, 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rdy", {31'd0, cpu_rdy},    32'd1);
    check("rst_mid_act", {31'd0, dma_active}, 32'd0);
    check("rst_mid_wn",  {31'd0, dma_wn},     32'd1);
    @(posedge clk); #1;
    check("rst_mid_rdy_next", {31'd0, cpu_rdy}, 32'd1);
    check("rst_mid_writes", wr_cnt, 32'd64);
    check("rst_mid_oam3f", {24'd0, oam[8'h3F]}, {24'd0, 8'h6F});
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("rst_mid_no_more", wr_cnt, 32'd64);
    check("rst_mid_idle", {31'd0, dma_busy}, 32'd0);

    // non-trigger accesses
    prep(8'h00);
    cpu_access(16'h4014, 1'b1, 8'h02);
    check("rd4014_rdy", {31'd0, cpu_rdy}, 32'd1);
    repeat (3) @(negedge clk);
    check("rd4014_busy", {31'd0, dma_busy}, 32'd0);
    cpu_access(16'h4015, 1'b0, 8'h02);
    check("wr4015_rdy", {31'd0, cpu_rdy}, 32'd1);
    repeat (3) @(negedge clk);
    check("wr4015_busy", {31'd0, dma_busy}, 32'd0);
    check("nontrig_writes", wr_cnt, 32'd0);
    check("nontrig_low", low_cnt, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
